pool_engine: RTL
================

// Module: pool_engine
// PURPOSE
//  Streaming 2-D pooling engine. Runs non-overlapping KxK max or average pooling (stride = K) over one raster-order feature-map frame of LANES parallel channels.
//  Sits between the buffer read path and the write-back path. Launched by a start pulse from the layer sequencer; pulses done when the frame is finished.
// PARAMETERS
//  DATA_W  16  signed element width per lane
//  LANES   4   channels processed in parallel per pixel beat
//  K_MAX   4   largest supported window size K
//  MAX_W   64  largest frame width; sets line-buffer depth MAX_W/1 and counter widths
// PORTS
//  clk         in   1               clock; single clock domain
//  rst         in   1               asynchronous reset, active-high
//  start       in   1               1-cycle pulse; latches cfg_*, starts a frame
//  cfg_k       in   $clog2(K_MAX)+1 window size K, 1..K_MAX
//  cfg_mode    in   1               0 = max, 1 = average
//  cfg_shift   in   4               average divisor as a right shift (sum >>> shift)
//  cfg_width   in   $clog2(MAX_W)+1 frame width W in pixels
//  cfg_height  in   16              frame height H in pixels
//  in_valid    in   1               input pixel valid
//  in_ready    out  1               engine accepts the pixel this cycle
//  in_data     in   LANES*DATA_W    pixel; lane i = bits [i*DATA_W +: DATA_W]
//  out_valid   out  1               pooled pixel valid
//  out_ready   in   1               downstream accepts the pooled pixel
//  out_data    out  LANES*DATA_W    pooled pixel, same lane packing as in_data
//  busy        out  1               high while not IDLE
//  done        out  1               1-cycle pulse at frame end
// BEHAVIOUR
//  Reset: state=IDLE. in_ready, out_valid, busy, done = 0. out_data = 0. All counters and accumulators = 0.
//  Reset mid-frame aborts the frame. No done pulse is issued.
//  FSM:
//   IDLE -> RUN on start.
//   IDLE -> DONE on start when cfg_k==0, cfg_k>K_MAX, W<K or H<K (degenerate frame: no outputs).
//   RUN -> DRAIN when the pixel at r=H-1, c=W-1 is accepted.
//   DRAIN -> DONE when out_valid==0 or the output handshake completes.
//   DONE -> IDLE after 1 cycle. done=1 only in DONE.
//  start outside IDLE is ignored. cfg_* are sampled only at start.
//  in_ready = (state==RUN) && (!out_valid || out_ready).
//  A beat is accepted when in_valid && in_ready. Counters: column c, row r, window column kc, window row kr.
//  Horizontal reduce: per lane, combine the beat into h_acc. Max is a signed compare; average is a signed sum of width ACC_W = DATA_W + $clog2(K_MAX*K_MAX). kc==0 loads h_acc.
//  At kc==K-1, vertical reduce into line buffer entry ox = c/K:
//   - kr==0: write h_acc.
//   - otherwise: combine with the stored entry.
//   - kr==K-1: the combined value goes to the output register. out_valid rises on the next cycle (latency 1 from the completing beat).
//  Tail pixels (c >= (W/K)*K or r >= (H/K)*K) are accepted and discarded. Output count = floor(W/K)*floor(H/K).
//  Output: average = (sum >>> cfg_shift), saturated to signed DATA_W. Max passes through unchanged.
//  out_data is held stable while out_valid && !out_ready.
//  K=1 is a pass-through: one output per input.
// CONFIGURATION
//  POOL_AVG_EN defined: cfg_mode=1 selects average; ACC_W accumulators are built.
//  POOL_AVG_EN undefined: cfg_mode and cfg_shift are ignored and max is always used. Accumulators are DATA_W wide.
// STRUCTURE
//  pool_pkg: pool_mode_e {POOL_MAX, POOL_AVG}; pool_state_e {IDLE, RUN, DRAIN, DONE}; ACC_W localparam function; lane pack/unpack helpers.
//  Sub-module pool_reduce_lane: one lane's combine (max/add, load/accumulate). Instantiated LANES times for each of the two stages.
//  Line buffer: register array [MAX_W] x LANES x ACC_W inside pool_engine.
// TESTING
//  1. Max, K=2, W=H=4, lane0 = raster index 0..15, out_ready=1 -> 4 outputs 5,7,13,15, then done 1 cycle later.
//  2. Avg, K=2, shift=2, all lanes=8, W=H=4 -> 4 outputs of 8. With POOL_AVG_EN undefined -> 4 outputs of 8 via max.
//  3. Saturation: avg, K=2, shift=0, all lanes=0x7FFF -> out 0x7FFF; all lanes=0x8000 -> out 0x8000.
//  4. Tails: K=3, W=7, H=5 -> exactly 2 outputs; all 35 beats accepted; done asserted.
//  5. Backpressure: out_ready=0 for 10 cycles after the first output -> in_ready=0 and out_data held stable; output stream identical to the out_ready=1 run.
//  6. Degenerate/abort: start with W=1,K=2 -> done 2 cycles later with no out_valid. rst asserted mid-RUN -> all outputs 0; next start runs cleanly.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and width helpers for pool_engine.
// POOL_AVG_EN widens the accumulators so average mode can be built.
package pool_pkg;

   typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pool_state_e;

`ifdef POOL_AVG_EN
   localparam bit AVG_EN = 1'b1;
`else
   localparam bit AVG_EN = 1'b0;
`endif

   // Sum of K*K signed values needs log2(K*K) guard bits.
   function automatic int unsigned acc_width(int unsigned data_w, int unsigned k_max);
      return data_w + (AVG_EN ? $clog2(k_max * k_max) : 0);
   endfunction

   function automatic int unsigned lane_lsb(int unsigned lane, int unsigned data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/pool_reduce_lane.sv
// One lane of the pooling combine: load, signed max, or signed add.
module pool_reduce_lane
   import pool_pkg::*;
#(
   parameter int unsigned ACC_W = 20
) (
   input  logic             i_load,
   input  logic             i_avg,
   input  logic [ACC_W-1:0] i_acc,
   input  logic [ACC_W-1:0] i_new,
   output logic [ACC_W-1:0] o_res
);

   always_comb begin
      o_res = i_acc;
      if (i_load)                              o_res = i_new;
      else if (i_avg)                          o_res = i_acc + i_new;
      else if ($signed(i_new) > $signed(i_acc)) o_res = i_new;
   end

endmodule

// File: rtl/pool_engine.sv
// Streaming KxK (stride K) max/average pooling over one raster-order frame.
// Build with POOL_AVG_EN to enable average mode; otherwise max is always used.
module pool_engine
   import pool_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LANES  = 4,
   parameter int unsigned K_MAX  = 4,
   parameter int unsigned MAX_W  = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [$clog2(K_MAX):0]   i_cfg_k,
   input  logic                     i_cfg_mode,
   input  logic [3:0]               i_cfg_shift,
   input  logic [$clog2(MAX_W):0]   i_cfg_width,
   input  logic [15:0]              i_cfg_height,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [LANES*DATA_W-1:0]  i_in_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [LANES*DATA_W-1:0]  o_out_data,
   output logic                     o_busy,
   output logic                     o_done
);

   localparam int unsigned ACC_W = acc_width(DATA_W, K_MAX);
   localparam int unsigned KW    = $clog2(K_MAX) + 1;
   localparam int unsigned CW    = $clog2(MAX_W) + 1;
   localparam int unsigned AW    = $clog2(MAX_W);

   pool_state_e             r_state;
   logic [KW-1:0]           r_k, r_kc, r_kr;
   logic [CW-1:0]           r_w, r_c, r_cs, r_ox;
   logic [15:0]             r_h, r_r, r_rs;
   logic [ACC_W-1:0]        r_h_acc [LANES];
   logic [ACC_W-1:0]        r_line  [MAX_W][LANES];
   logic                    r_out_valid;
   logic [LANES*DATA_W-1:0] r_out_data;

   logic [ACC_W-1:0]        w_h_new [LANES];
   logic [ACC_W-1:0]        w_v_new [LANES];
   logic [LANES*DATA_W-1:0] w_out_next;
   logic w_accept, w_kc_last, w_kr_last, w_c_last, w_r_last, w_col_ok, w_row_ok, w_emit;
   logic w_degen, w_avg;

`ifdef POOL_AVG_EN
   pool_mode_e r_mode;
   logic [3:0] r_shift;
   logic [3:0] w_shift;
   assign w_avg   = (r_mode == POOL_AVG);
   assign w_shift = w_avg ? r_shift : 4'd0;
`else
   logic w_unused;
   assign w_avg    = 1'b0;
   assign w_unused = ^{i_cfg_mode, i_cfg_shift};
`endif

   assign o_in_ready  = (r_state == RUN) && (!r_out_valid || i_out_ready);
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = (r_state == DONE);

   assign w_accept  = i_in_valid && o_in_ready;
   assign w_kc_last = (r_kc == r_k - KW'(1));
   assign w_kr_last = (r_kr == r_k - KW'(1));
   assign w_c_last  = (r_c == r_w - CW'(1));
   assign w_r_last  = (r_r == r_h - 16'd1);
   // A window contributes only if it fits entirely inside the frame.
   assign w_col_ok  = ({1'b0, r_cs} + (CW+1)'(r_k)) <= {1'b0, r_w};
   assign w_row_ok  = ({1'b0, r_rs} + 17'(r_k)) <= {1'b0, r_h};
   assign w_emit    = w_kc_last && w_col_ok && w_row_ok;
   assign w_degen   = (i_cfg_k == '0) || (i_cfg_k > KW'(K_MAX)) ||
                      (CW'(i_cfg_k) > i_cfg_width) || (16'(i_cfg_k) > i_cfg_height);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [ACC_W-1:0]  w_beat;
      logic [DATA_W-1:0] w_sat;

      assign w_beat = ACC_W'($signed(i_in_data[lane_lsb(l, DATA_W) +: DATA_W]));

      pool_reduce_lane #(.ACC_W(ACC_W)) u_h_reduce (
         .i_load (r_kc == '0),
         .i_avg  (w_avg),
         .i_acc  (r_h_acc[l]),
         .i_new  (w_beat),
         .o_res  (w_h_new[l])
      );

      pool_reduce_lane #(.ACC_W(ACC_W)) u_v_reduce (
         .i_load (r_kr == '0),
         .i_avg  (w_avg),
         .i_acc  (r_line[r_ox[AW-1:0]][l]),
         .i_new  (w_h_new[l]),
         .o_res  (w_v_new[l])
      );

`ifdef POOL_AVG_EN
      logic [ACC_W-1:0]        w_shifted;
      logic [ACC_W-DATA_W:0]   w_hi;
      assign w_shifted = $signed(w_v_new[l]) >>> w_shift;
      assign w_hi      = w_shifted[ACC_W-1:DATA_W-1];
      // Upper bits all equal means the value fits in DATA_W.
      assign w_sat = (&w_hi || ~|w_hi) ? w_shifted[DATA_W-1:0] :
                     w_shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                          {1'b0, {(DATA_W-1){1'b1}}};
`else
      assign w_sat = w_v_new[l];
`endif

      assign w_out_next[lane_lsb(l, DATA_W) +: DATA_W] = w_sat;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_kc        <= '0;
         r_kr        <= '0;
         r_w         <= '0;
         r_c         <= '0;
         r_cs        <= '0;
         r_ox        <= '0;
         r_h         <= '0;
         r_r         <= '0;
         r_rs        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
`ifdef POOL_AVG_EN
         r_mode      <= POOL_MAX;
         r_shift     <= '0;
`endif
         for (int l = 0; l < LANES; l++) r_h_acc[l] <= '0;
         for (int i = 0; i < MAX_W; i++)
            for (int l = 0; l < LANES; l++) r_line[i][l] <= '0;
      end else begin
         if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
         unique case (r_state)
            IDLE: if (i_start) begin
               r_k  <= i_cfg_k;
               r_w  <= i_cfg_width;
               r_h  <= i_cfg_height;
`ifdef POOL_AVG_EN
               r_mode  <= pool_mode_e'(i_cfg_mode);
               r_shift <= i_cfg_shift;
`endif
               r_c  <= '0;
               r_r  <= '0;
               r_kc <= '0;
               r_kr <= '0;
               r_cs <= '0;
               r_rs <= '0;
               r_ox <= '0;
               r_state <= w_degen ? DONE : RUN;
            end
            RUN: if (w_accept) begin
               for (int l = 0; l < LANES; l++) r_h_acc[l] <= w_h_new[l];
               if (w_emit) begin
                  for (int l = 0; l < LANES; l++) r_line[r_ox[AW-1:0]][l] <= w_v_new[l];
                  if (w_kr_last) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_out_next;
                  end
               end
               if (w_c_last) begin
                  r_c  <= '0;
                  r_kc <= '0;
                  r_cs <= '0;
                  r_ox <= '0;
                  if (w_r_last) begin
                     r_state <= DRAIN;
                  end else begin
                     r_r <= r_r + 16'd1;
                     if (w_kr_last) begin
                        r_kr <= '0;
                        r_rs <= r_rs + 16'(r_k);
                     end else begin
                        r_kr <= r_kr + KW'(1);
                     end
                  end
               end else begin
                  r_c <= r_c + CW'(1);
                  if (w_kc_last) begin
                     r_kc <= '0;
                     r_cs <= r_cs + CW'(r_k);
                     r_ox <= r_ox + CW'(1);
                  end else begin
                     r_kc <= r_kc + KW'(1);
                  end
               end
            end
            DRAIN: if (!r_out_valid || i_out_ready) r_state <= DONE;
            DONE:  r_state <= IDLE;
         endcase
      end
   end

endmodule
